// File: rtl/rle_pkg.sv
// Shared run-length stream format: state encoding and header word layout.
// Used by both the compressor and the decompressor so the two ends agree.
package rle_pkg;

    localparam int unsigned DataWDefault = 16;

    typedef enum logic [2:0] {
        StFirst,
        StScan,
        StWaitIn,
        StFlush,
        StFdrain
    } rle_state_e;

    // Header carries only the value of the first bit in the stream, in bit 0
    function automatic logic [63:0] rle_header(input logic first_bit);
        return {63'b0, first_bit};
    endfunction

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry holding register for compressed words toward DMA.
// Slot is free when empty or when the held word is being accepted this edge.
module rle_out_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              emit_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              free_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign free_o  = !valid_q || ack_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (emit_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (ack_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_compressor.sv
// Run-length encoder: header word with the first bit value, then alternating run lengths.
// Saturated runs are split as RUN_MAX followed by a zero-length opposite run.
module rle_compressor
    import rle_pkg::*;
#(
    parameter int unsigned DATA_W  = DataWDefault,
    parameter int unsigned RUN_MAX = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              load,
    output logic              done,
    input  logic              flush,
    output logic              flush_done,
    output logic [DATA_W-1:0] Dout,
    output logic              DMA_en,
    input  logic              DMA_ack
);

    localparam int unsigned       IdxW    = $clog2(DATA_W) + 1;
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(DATA_W - 1);
    localparam logic [IdxW-1:0]   AllIdx  = IdxW'(DATA_W);
    localparam logic [DATA_W-1:0] RunMax  = DATA_W'(RUN_MAX);

    rle_state_e        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0] run_q, run_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic              cur_bit_q, cur_bit_d;
    logic              pend_zero_q, pend_zero_d;
    logic              flush_done_q, flush_done_d;

    logic              emit;
    logic [DATA_W-1:0] emit_data;
    logic              slot_free;
    logic              advance;
    logic              scan_bit;

    // The shift register is consumed LSB first, so the current bit is always bit 0
    assign scan_bit   = sreg_q[0];
    assign done       = (state_q == StFirst) || (state_q == StWaitIn);
    assign flush_done = flush_done_q;

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        run_d        = run_q;
        bit_idx_d    = bit_idx_q;
        cur_bit_d    = cur_bit_q;
        pend_zero_d  = pend_zero_q;
        flush_done_d = 1'b0;
        emit         = 1'b0;
        emit_data    = '0;
        advance      = 1'b0;

        unique case (state_q)
            StFirst: begin
                if (load && slot_free) begin
                    sreg_d    = Din;
                    cur_bit_d = Din[0];
                    emit      = 1'b1;
                    emit_data = DATA_W'(rle_header(Din[0]));
                    run_d     = '0;
                    bit_idx_d = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (pend_zero_q) begin
                    if (slot_free) begin
                        emit        = 1'b1;
                        pend_zero_d = 1'b0;
                        if (bit_idx_q == AllIdx) state_d = StWaitIn;
                    end
                end else begin
                    if (scan_bit == cur_bit_q && run_q != RunMax) begin
                        run_d   = run_q + DATA_W'(1);
                        advance = 1'b1;
                    end else if (slot_free) begin
                        emit    = 1'b1;
                        advance = 1'b1;
                        run_d   = DATA_W'(1);
                        if (scan_bit == cur_bit_q) begin
                            emit_data   = RunMax;
                            pend_zero_d = 1'b1;
                        end else begin
                            emit_data = run_q;
                            cur_bit_d = ~cur_bit_q;
                        end
                    end
                    if (advance) begin
                        sreg_d    = sreg_q >> 1;
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        if (bit_idx_q == LastIdx && !pend_zero_d) state_d = StWaitIn;
                    end
                end
            end
            StWaitIn: begin
                if (load) begin
                    sreg_d    = Din;
                    bit_idx_d = '0;
                    state_d   = StScan;
                end else if (flush) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_data = run_q;
                    state_d   = StFdrain;
                end
            end
            StFdrain: begin
                if (DMA_en && DMA_ack) begin
                    flush_done_d = 1'b1;
                    state_d      = StFirst;
                end
            end
            default: state_d = StFirst;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFirst;
            sreg_q       <= '0;
            run_q        <= '0;
            bit_idx_q    <= '0;
            cur_bit_q    <= 1'b0;
            pend_zero_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            run_q        <= run_d;
            bit_idx_q    <= bit_idx_d;
            cur_bit_q    <= cur_bit_d;
            pend_zero_q  <= pend_zero_d;
            flush_done_q <= flush_done_d;
        end
    end

    rle_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .emit_i (emit),
        .data_i (emit_data),
        .ack_i  (DMA_ack),
        .data_o (Dout),
        .valid_o(DMA_en),
        .free_o (slot_free)
    );

endmodule
